// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg -- shared definitions for the AXI4-Stream FIFO.
//   beat_t      : one stored beat (all payload fields) at the default widths
//   ptr_width() : pointer width for a given depth (address bits + wrap bit)
//   beat_width(): flattened record width for arbitrary field widths
// -----------------------------------------------------------------------------
package axis_pkg;

  localparam int AXIS_DATA_WIDTH = 32;
  localparam int AXIS_ID_WIDTH   = 4;
  localparam int AXIS_DEST_WIDTH = 4;
  localparam int AXIS_USER_WIDTH = 16;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0]   tdata;
    logic [AXIS_DATA_WIDTH/8-1:0] tstrb;
    logic [AXIS_DATA_WIDTH/8-1:0] tkeep;
    logic [AXIS_ID_WIDTH-1:0]     tid;
    logic [AXIS_DEST_WIDTH-1:0]   tdest;
    logic [AXIS_USER_WIDTH-1:0]   tuser;
    logic                         tlast;
  } beat_t;

  // One extra bit above the address distinguishes full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int beat_width(input int dw, input int iw, input int destw, input int uw);
    return dw + 2 * (dw / 8) + iw + destw + uw + 1;
  endfunction

endpackage

// File: rtl/axis_if.sv
// -----------------------------------------------------------------------------
// axis -- AXI4-Stream interface bundle.
//   master modport: drives tvalid and payload, samples tready
//   slave  modport: samples tvalid and payload, drives tready
// -----------------------------------------------------------------------------
interface axis #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 16
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;
  logic                    tlast;

  modport master (output tvalid, tdata, tstrb, tkeep, tid, tdest, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tstrb, tkeep, tid, tdest, tuser, tlast, output tready);
endinterface

// File: rtl/axis_fifo_mem.sv
// -----------------------------------------------------------------------------
// axis_fifo_mem -- simple dual-port RAM, synchronous write, registered read.
//   clk, rst_n   : clock, async active-low reset (output register only)
//   we/waddr/wdata : write port
//   raddr/rdata  : read port, rdata valid one edge after raddr
// A write to the address being read is forwarded into rdata (write-first),
// which lets a beat written into an empty FIFO appear one cycle later.
// -----------------------------------------------------------------------------
module axis_fifo_mem #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     rdata <= '0;
    else if (we && waddr == raddr)  rdata <= wdata;
    else                            rdata <= mem[raddr];
  end
endmodule

// File: rtl/axis_fifo.sv
// -----------------------------------------------------------------------------
// axis_fifo -- synchronous AXI4-Stream FIFO, first-word-fall-through.
//   aclk, aresetn : clock, asynchronous active-low reset
//   s_axis        : upstream stream (slave)
//   m_axis        : downstream stream (master)
//   count         : current occupancy, 0..DEPTH
// Optional macro AXIS_FIFO_PACKET_MODE_EN: store-and-forward; m_axis.tvalid is
// held low until at least one complete packet (tlast) is stored.
// -----------------------------------------------------------------------------
module axis_fifo
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  axis.slave                     s_axis,
  axis.master                    m_axis,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = ptr_width(DEPTH);
  localparam int REC_W = beat_width(DATA_WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;
    logic [USER_WIDTH-1:0]   tuser;
    logic                    tlast;
  } rec_t;

  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]    count_reg, count_next;
  logic             ready_reg;
  logic             push, pop, empty, full_next, out_valid;
  rec_t             wr_rec, rd_rec;
  logic [REC_W-1:0] wr_word, rd_word;

  assign push  = s_axis.tvalid && ready_reg;
  assign pop   = out_valid && m_axis.tready;
  assign empty = (wr_ptr_reg == rd_ptr_reg);

  always_comb begin
    wr_ptr_next = wr_ptr_reg + PW'(push);
    rd_ptr_next = rd_ptr_reg + PW'(pop);
    count_next  = count_reg + PW'(push) - PW'(pop);
    // tready is registered from the post-update pointers, so a pop while
    // full only reopens the input on the following cycle.
    full_next   = (wr_ptr_next[PW-1] != rd_ptr_next[PW-1]) &&
                  (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ready_reg  <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      ready_reg  <= !full_next;
    end
  end

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [PW-1:0] pkt_count_reg, pkt_count_next;
  logic          full;

  assign full = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  always_comb begin
    pkt_count_next = pkt_count_reg + PW'(push && s_axis.tlast) - PW'(pop && rd_rec.tlast);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) pkt_count_reg <= '0;
    else          pkt_count_reg <= pkt_count_next;
  end

  assign out_valid = !empty && (pkt_count_reg != '0);

  // Full with no complete packet stored can never drain: packet too long.
  packet_fits_depth: assert property (@(posedge aclk) disable iff (!aresetn)
                                      !(full && pkt_count_reg == '0));
`else
  assign out_valid = !empty;
`endif

  assign wr_rec.tdata = s_axis.tdata;
  assign wr_rec.tstrb = s_axis.tstrb;
  assign wr_rec.tkeep = s_axis.tkeep;
  assign wr_rec.tid   = s_axis.tid;
  assign wr_rec.tdest = s_axis.tdest;
  assign wr_rec.tuser = s_axis.tuser;
  assign wr_rec.tlast = s_axis.tlast;
  assign wr_word      = wr_rec;
  assign rd_rec       = rd_word;

  // Read address runs one step ahead so the output register always holds
  // the head entry after each edge.
  axis_fifo_mem #(
    .WIDTH      (REC_W),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) u_mem (
    .clk   (aclk),
    .rst_n (aresetn),
    .we    (push),
    .waddr (wr_ptr_reg[AW-1:0]),
    .wdata (wr_word),
    .raddr (rd_ptr_next[AW-1:0]),
    .rdata (rd_word)
  );

  assign s_axis.tready = ready_reg;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = rd_rec.tdata;
  assign m_axis.tstrb  = rd_rec.tstrb;
  assign m_axis.tkeep  = rd_rec.tkeep;
  assign m_axis.tid    = rd_rec.tid;
  assign m_axis.tdest  = rd_rec.tdest;
  assign m_axis.tuser  = rd_rec.tuser;
  assign m_axis.tlast  = rd_rec.tlast;
  assign count         = count_reg;
endmodule

// File: tb/tb_axis_fifo.sv
// -----------------------------------------------------------------------------
// tb_axis_fifo -- self-checking bench for axis_fifo (DEPTH 16, default widths).
// Reference model: a queue of beats; valid/ready/count derive from its size
// (and, with AXIS_FIFO_PACKET_MODE_EN, from whether it holds any tlast beat).
// -----------------------------------------------------------------------------
module tb_axis_fifo;
  import axis_pkg::*;

  localparam int DEPTH = 16;

  logic       aclk;
  logic       aresetn;
  logic [4:0] count;

  axis #(.DATA_WIDTH(32), .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(16)) s_if ();
  axis #(.DATA_WIDTH(32), .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(16)) m_if ();

  axis_fifo #(
    .DATA_WIDTH (32),
    .ID_WIDTH   (4),
    .DEST_WIDTH (4),
    .USER_WIDTH (16),
    .DEPTH      (DEPTH)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axis  (s_if),
    .m_axis  (m_if),
    .count   (count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int    n_vec = 0;
  int    n_err = 0;
  beat_t q[$];
  bit    rdy_en = 0;
  bit    last_push, last_pop;

  // ---------------- reference model ----------------
  function automatic bit exp_valid();
    if (q.size() == 0) return 1'b0;
`ifdef AXIS_FIFO_PACKET_MODE_EN
    foreach (q[i]) if (q[i].tlast) return 1'b1;
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit exp_ready();
    return rdy_en && (q.size() < DEPTH);
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic beat_t mk(input logic [31:0] d, input logic last);
    beat_t b;
    b       = '0;
    b.tdata = d;
    b.tstrb = '1;
    b.tkeep = '1;
    b.tid   = d[3:0];
    b.tdest = d[7:4];
    b.tuser = d[15:0];
    b.tlast = last;
    return b;
  endfunction

  function automatic beat_t rand_beat(input int k);
    beat_t b;
    b.tdata = $urandom;
    b.tstrb = 4'($urandom);
    b.tkeep = 4'($urandom);
    b.tid   = 4'($urandom);
    b.tdest = 4'($urandom);
    b.tuser = 16'($urandom);
    b.tlast = (k == 999) || (k % 8 == 7) || (($urandom % 5) == 0);
    return b;
  endfunction

  task automatic set_in(input beat_t b, input logic v);
    s_if.tvalid = v;
    s_if.tdata  = b.tdata;
    s_if.tstrb  = b.tstrb;
    s_if.tkeep  = b.tkeep;
    s_if.tid    = b.tid;
    s_if.tdest  = b.tdest;
    s_if.tuser  = b.tuser;
    s_if.tlast  = b.tlast;
  endtask

  function automatic beat_t cur_in();
    beat_t b;
    b.tdata = s_if.tdata;  b.tstrb = s_if.tstrb; b.tkeep = s_if.tkeep;
    b.tid   = s_if.tid;    b.tdest = s_if.tdest; b.tuser = s_if.tuser;
    b.tlast = s_if.tlast;
    return b;
  endfunction

  function automatic beat_t cur_out();
    beat_t b;
    b.tdata = m_if.tdata;  b.tstrb = m_if.tstrb; b.tkeep = m_if.tkeep;
    b.tid   = m_if.tid;    b.tdest = m_if.tdest; b.tuser = m_if.tuser;
    b.tlast = m_if.tlast;
    return b;
  endfunction

  // Advance one clock; the model applies the handshakes it expects.
  task automatic step();
    bit    push, pop;
    beat_t inb;
    push = s_if.tvalid && exp_ready();
    pop  = exp_valid() && m_if.tready;
    inb  = cur_in();
    @(posedge aclk);
    if (!aresetn) begin
      q.delete();
      rdy_en = 0;
      push   = 0;
      pop    = 0;
    end else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(inb);
      rdy_en = 1;
    end
    last_push = push;
    last_pop  = pop;
    #1;
  endtask

  task automatic drain();
    int n = 0;
    set_in('0, 1'b0);
    m_if.tready = 1'b1;
    while (q.size() > 0 && n < 300) begin
      n_vec++;
      if (m_if.tvalid !== exp_valid())
        $display("FAIL drain_valid: got %0b want %0b", m_if.tvalid, exp_valid());
      else if (m_if.tvalid && cur_out() !== q[0]) begin
        n_err++;
        $display("FAIL drain_beat: got %h want %h", cur_out(), q[0]);
      end
      if (m_if.tvalid !== exp_valid()) n_err++;
      step();
      n++;
    end
    n_vec++;
    if (n >= 300) begin n_err++; $display("FAIL drain_timeout: got %0d left want 0", q.size()); end
    n_vec++;
    if (count !== 5'd0) begin n_err++; $display("FAIL drain_count: got %0d want 0", count); end
    m_if.tready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    aresetn = 1'b0;
    set_in('0, 1'b0);
    m_if.tready = 1'b0;
    q.delete();
    rdy_en = 0;
    repeat (3) @(posedge aclk);
    #1;
    n_vec++; if (count !== 5'd0)      begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_vec++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", m_if.tvalid); end
    n_vec++; if (s_if.tready !== 1'b0) begin n_err++; $display("FAIL reset_tready: got %b want 0", s_if.tready); end
    n_vec++; if (m_if.tdata !== 32'd0) begin n_err++; $display("FAIL reset_tdata: got %h want 0", m_if.tdata); end
    aresetn = 1'b1;
    #1;
    n_vec++; if (s_if.tready !== 1'b0) begin n_err++; $display("FAIL release_tready_early: got %b want 0", s_if.tready); end
    step();
    n_vec++; if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL release_tready: got %b want 1", s_if.tready); end
  endtask

  task automatic test_basic();
    logic [31:0] words [3];
    int sent = 0, got = 0, cyc = 0, acc_cyc = -1, vld_cyc = -1;
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    m_if.tready = 1'b1;
    while ((sent < 3 || got < 3) && cyc < 50) begin
      if (sent < 3) set_in(mk(words[sent], 1'b1), 1'b1);
      else          set_in('0, 1'b0);
      if (m_if.tvalid === 1'b1) begin
        if (vld_cyc < 0) vld_cyc = cyc;
        n_vec++;
        if (got >= 3 || m_if.tdata !== words[got]) begin
          n_err++;
          $display("FAIL basic_data: got %h want %h", m_if.tdata, (got < 3) ? words[got] : 32'hx);
        end
        got++;
      end
      step();
      if (last_push && acc_cyc < 0) acc_cyc = cyc;
      if (last_push) sent++;
      cyc++;
    end
    n_vec++; if (cyc >= 50) begin n_err++; $display("FAIL basic_timeout: got %0d beats want 3", got); end
    n_vec++; if (vld_cyc != acc_cyc + 1) begin n_err++; $display("FAIL basic_latency: got %0d want 1", vld_cyc - acc_cyc); end
    n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL basic_count: got %0d want 0", count); end
    m_if.tready = 1'b0;
  endtask

  task automatic test_full();
    int acc = 0;
    m_if.tready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      set_in(mk(32'h100 + acc, 1'b1), 1'b1);
      if (s_if.tready === 1'b1) acc++;
      step();
    end
    n_vec++; if (acc != 16) begin n_err++; $display("FAIL full_accepted: got %0d want 16", acc); end
    n_vec++; if (count !== 5'd16) begin n_err++; $display("FAIL full_count: got %0d want 16", count); end
    n_vec++; if (s_if.tready !== 1'b0) begin n_err++; $display("FAIL full_tready: got %b want 0", s_if.tready); end
    n_vec++; if (m_if.tdata !== 32'h100) begin n_err++; $display("FAIL full_head: got %h want 100", m_if.tdata); end
    // one pop while the 17th beat waits
    m_if.tready = 1'b1;
    step();
    m_if.tready = 1'b0;
    n_vec++; if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL pop_tready_restore: got %b want 1", s_if.tready); end
    n_vec++; if (count !== 5'd15) begin n_err++; $display("FAIL pop_count: got %0d want 15", count); end
    step();
    n_vec++; if (count !== 5'd16) begin n_err++; $display("FAIL beat17_count: got %0d want 16", count); end
    n_vec++; if (m_if.tdata !== 32'h101) begin n_err++; $display("FAIL beat17_head: got %h want 101", m_if.tdata); end
    drain();
  endtask

  task automatic test_back_to_back();
    m_if.tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_in(mk(32'h1000 + k, 1'b1), 1'b1);
      step();
    end
    m_if.tready = 1'b1;
    for (int j = 0; j < 100; j++) begin
      set_in(mk(32'h1000 + 3 + j, 1'b1), 1'b1);
      n_vec++; if (count !== 5'd3)     begin n_err++; $display("FAIL b2b_count: cycle %0d got %0d want 3", j, count); end
      n_vec++; if (m_if.tvalid !== 1'b1) begin n_err++; $display("FAIL b2b_tvalid: cycle %0d got %b want 1", j, m_if.tvalid); end
      n_vec++; if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL b2b_tready: cycle %0d got %b want 1", j, s_if.tready); end
      n_vec++; if (m_if.tdata !== 32'h1000 + j) begin n_err++; $display("FAIL b2b_data: cycle %0d got %h want %h", j, m_if.tdata, 32'h1000 + j); end
      step();
    end
    drain();
  endtask

  task automatic test_random();
    int    sent = 0, cyc = 0;
    beat_t nb, prev;
    bit    prev_stall = 0;
    nb   = rand_beat(0);
    prev = '0;
    while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
      set_in(nb, (sent < 1000) && (($urandom % 10) < 7));
      m_if.tready = (($urandom % 10) < 6);
      n_vec++; if (m_if.tvalid !== exp_valid()) begin n_err++; $display("FAIL rand_tvalid: cycle %0d got %b want %b", cyc, m_if.tvalid, exp_valid()); end
      n_vec++; if (s_if.tready !== exp_ready()) begin n_err++; $display("FAIL rand_tready: cycle %0d got %b want %b", cyc, s_if.tready, exp_ready()); end
      n_vec++; if (count !== 5'(q.size())) begin n_err++; $display("FAIL rand_count: cycle %0d got %0d want %0d", cyc, count, q.size()); end
      if (exp_valid()) begin
        n_vec++;
        if (cur_out() !== q[0]) begin n_err++; $display("FAIL rand_beat: cycle %0d got %h want %h", cyc, cur_out(), q[0]); end
      end
      if (prev_stall) begin
        n_vec++;
        if (cur_out() !== prev || m_if.tvalid !== 1'b1) begin
          n_err++;
          $display("FAIL rand_stall_stable: cycle %0d got %h want %h", cyc, cur_out(), prev);
        end
      end
      prev_stall = (m_if.tvalid === 1'b1) && !m_if.tready;
      prev       = cur_out();
      step();
      if (last_push) begin
        sent++;
        nb = rand_beat(sent);
      end
      cyc++;
    end
    n_vec++; if (cyc >= 20000) begin n_err++; $display("FAIL rand_timeout: got %0d sent, %0d queued want 1000, 0", sent, q.size()); end
    set_in('0, 1'b0);
    m_if.tready = 1'b0;
  endtask

`ifdef AXIS_FIFO_PACKET_MODE_EN
  task automatic test_packet();
    m_if.tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_in(mk(32'h300 + k, 1'b0), 1'b1);
      step();
      n_vec++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL pkt_early_valid: beat %0d got %b want 0", k, m_if.tvalid); end
    end
    set_in('0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL pkt_stall_valid: got %b want 0", m_if.tvalid); end
    end
    set_in(mk(32'h303, 1'b1), 1'b1);
    step();
    set_in('0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      n_vec++; if (m_if.tvalid !== 1'b1) begin n_err++; $display("FAIL pkt_out_valid: beat %0d got %b want 1", j, m_if.tvalid); end
      n_vec++; if (m_if.tdata !== 32'h300 + j) begin n_err++; $display("FAIL pkt_out_data: got %h want %h", m_if.tdata, 32'h300 + j); end
      step();
    end
    n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL pkt_count: got %0d want 0", count); end
    m_if.tready = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    m_if.tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_in(mk(32'h200 + k, 1'b0), 1'b1);
      step();
    end
    set_in('0, 1'b0);
    n_vec++; if (count !== 5'd5) begin n_err++; $display("FAIL mid_pre_count: got %0d want 5", count); end
    #2;
    aresetn = 1'b0;
    q.delete();
    rdy_en = 0;
    #1;
    n_vec++; if (count !== 5'd0)       begin n_err++; $display("FAIL mid_count: got %0d want 0", count); end
    n_vec++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL mid_tvalid: got %b want 0", m_if.tvalid); end
    n_vec++; if (s_if.tready !== 1'b0) begin n_err++; $display("FAIL mid_tready: got %b want 0", s_if.tready); end
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    step();
    set_in(mk(32'hAA, 1'b1), 1'b1);
    m_if.tready = 1'b1;
    step();
    set_in('0, 1'b0);
    n_vec++; if (m_if.tvalid !== 1'b1) begin n_err++; $display("FAIL mid_new_valid: got %b want 1", m_if.tvalid); end
    n_vec++; if (m_if.tdata !== 32'hAA) begin n_err++; $display("FAIL mid_new_data: got %h want aa", m_if.tdata); end
    step();
    n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL mid_final_count: got %0d want 0", count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_random();
`ifdef AXIS_FIFO_PACKET_MODE_EN
    test_packet();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit");
  end
endmodule
